// File: rtl/dc_useq.sv
// dc_useq -- microsequencer for the F11 microcode store.
//
// Drives the registered MicROM (address, fetch enable, AX page bit) and
// consumes the returned next-address field and microword. Each advancing
// cycle executes the visible word and issues the next address in the same
// clock. The next address comes from the link field, a conditional branch,
// a 4-deep subroutine stack, the PLA map address, or the trap vector.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   stall           datapath not ready; freezes sequencing
//   cond            branch / wait condition for the visible word
//   map_addr[8:0]   PLA map target
//   trap            level trap request, held until trap_ack
//   rom_ma[8:0]     next-address field of the visible word
//   rom_mc[15:0]    microword of the visible word
//   rom_a[9:0]      MicROM address {ax, addr}
//   rom_cen         MicROM fetch enable
//   uop[15:0]       microword presented to the datapath
//   uop_valid       datapath executes uop this cycle
//   upc[8:0]        address of the word in uop
//   trap_ack        one-cycle pulse when a trap is taken
//   stk_err         sticky stack overflow / underflow flag
//   dbg_state[1:0]  sequencer state (0 RST, 1 FETCH, 2 RUN)
//   dbg_depth[2:0]  subroutine stack depth
//
// Handshake: uop_valid is a strict valid qualifier driven from the
// sequencer side; stall acts as the datapath's inverted ready. A word is
// consumed (and its side effects committed) only on a cycle where
// uop_valid=1, i.e. in RUN with stall=0 and no unmet WAIT.

module dc_useq #(
  parameter logic [8:0] RESET_VEC = 9'h080,
  parameter logic [8:0] TRAP_VEC  = 9'h081
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        cond,
  input  logic [8:0]  map_addr,
  input  logic        trap,
  input  logic [8:0]  rom_ma,
  input  logic [15:0] rom_mc,
  output logic [9:0]  rom_a,
  output logic        rom_cen,
  output logic [15:0] uop,
  output logic        uop_valid,
  output logic [8:0]  upc,
  output logic        trap_ack,
  output logic        stk_err,
  output logic [1:0]  dbg_state,
  output logic [2:0]  dbg_depth
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_NEXT  = 3'd0,
    OP_BR    = 3'd1,
    OP_CALL  = 3'd2,
    OP_RET   = 3'd3,
    OP_MAP   = 3'd4,
    OP_SETAX = 3'd5,
    OP_CLRAX = 3'd6,
    OP_WAIT  = 3'd7
  } op_t;

  state_t     state;
  logic       ax;
  logic [2:0] depth;
  logic [8:0] stk [0:3];

  op_t        op;
  logic       is_run;
  logic       is_fetch;
  logic       advance;
  logic       take_trap;
  logic       do_push;
  logic       do_pop;
  logic [8:0] pop_val;
  logic [8:0] next_addr;
  logic       ax_nxt;

  assign op       = op_t'(rom_mc[15:13]);
  assign is_run   = (state == ST_RUN);
  assign is_fetch = (state == ST_FETCH);

  // A WAIT word holds the sequencer (no fetch, not executed) until cond.
  assign advance   = is_run & ~stall & ~((op == OP_WAIT) & ~cond);
  assign take_trap = advance & trap;

  // Stack side effects of a trapped word are dropped so the handler sees
  // the stack exactly as it was before the interrupted word.
  assign do_push = advance & ~trap & (op == OP_CALL);
  assign do_pop  = advance & ~trap & (op == OP_RET);

  // Top of stack lives at index depth-1; depth 4 wraps to index 3.
  assign pop_val = (depth == 3'd0) ? 9'h000 : stk[depth[1:0] - 2'd1];

  always_comb begin
    next_addr = rom_ma;
    ax_nxt    = ax;
    case (op)
      OP_NEXT:  next_addr = rom_ma;
      OP_BR:    next_addr = cond ? rom_ma : (rom_ma | 9'h001);
      OP_CALL:  next_addr = rom_mc[8:0];
      OP_RET:   next_addr = pop_val;
      OP_MAP:   next_addr = map_addr;
      OP_SETAX: ax_nxt    = 1'b1;
      OP_CLRAX: ax_nxt    = 1'b0;
      OP_WAIT:  next_addr = rom_ma;
      default:  next_addr = rom_ma;
    endcase
    if (trap) begin
      next_addr = TRAP_VEC;
      ax_nxt    = 1'b0;
    end
  end

  // The AX update is folded into the address issued alongside the word
  // that changes it, so the very next fetch already uses the new page.
  always_comb begin
    rom_a = 10'h000;
    if (is_fetch)
      rom_a = {1'b0, RESET_VEC};
    else if (is_run)
      rom_a = {ax_nxt, next_addr};
  end

  assign rom_cen   = advance | is_fetch;
  assign uop       = rom_mc;
  assign uop_valid = advance;
  assign trap_ack  = take_trap;
  assign dbg_state = state;
  assign dbg_depth = depth;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_RST;
      upc     <= 9'h000;
      ax      <= 1'b0;
      depth   <= 3'd0;
      stk_err <= 1'b0;
      stk[0]  <= 9'h000;
      stk[1]  <= 9'h000;
      stk[2]  <= 9'h000;
      stk[3]  <= 9'h000;
    end else begin
      case (state)
        ST_RST:   state <= ST_FETCH;
        ST_FETCH: state <= ST_RUN;
        ST_RUN:   state <= ST_RUN;
        default:  state <= ST_RST;
      endcase

      if (rom_cen)
        upc <= rom_a[8:0];

      if (advance)
        ax <= ax_nxt;

      if (do_push) begin
        if (depth == 3'd4) begin
          // Full: drop the oldest return address and keep the newest four.
          stk[0]  <= stk[1];
          stk[1]  <= stk[2];
          stk[2]  <= stk[3];
          stk[3]  <= rom_ma;
          stk_err <= 1'b1;
        end else begin
          stk[depth[1:0]] <= rom_ma;
          depth           <= depth + 3'd1;
        end
      end else if (do_pop) begin
        if (depth == 3'd0)
          stk_err <= 1'b1;
        else
          depth <= depth - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_dc_useq.sv
// tb_dc_useq -- self-checking bench for dc_useq.
//
// A behavioural registered MicROM (latency 1, holds while rom_cen=0) feeds
// the sequencer. Each test loads a small microprogram, pushes the address
// sequence it expects the sequencer to fetch into exp_q, then steps the
// clock and pops one entry for every cycle with rom_cen=1.

module tb_dc_useq;

  localparam logic [2:0] NEXT  = 3'd0;
  localparam logic [2:0] BR    = 3'd1;
  localparam logic [2:0] CALL  = 3'd2;
  localparam logic [2:0] RET   = 3'd3;
  localparam logic [2:0] MAP   = 3'd4;
  localparam logic [2:0] SETAX = 3'd5;
  localparam logic [2:0] CLRAX = 3'd6;
  localparam logic [2:0] WAITO = 3'd7;

  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        cond = 1'b0;
  logic [8:0]  map_addr = 9'h000;
  logic        trap = 1'b0;
  logic [8:0]  rom_ma = 9'h000;
  logic [15:0] rom_mc = 16'h0000;
  logic [9:0]  rom_a;
  logic        rom_cen;
  logic [15:0] uop;
  logic        uop_valid;
  logic [8:0]  upc;
  logic        trap_ack;
  logic        stk_err;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_depth;

  dc_useq dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .cond      (cond),
    .map_addr  (map_addr),
    .trap      (trap),
    .rom_ma    (rom_ma),
    .rom_mc    (rom_mc),
    .rom_a     (rom_a),
    .rom_cen   (rom_cen),
    .uop       (uop),
    .uop_valid (uop_valid),
    .upc       (upc),
    .trap_ack  (trap_ack),
    .stk_err   (stk_err),
    .dbg_state (dbg_state),
    .dbg_depth (dbg_depth)
  );

  // behavioural MicROM
  logic [8:0]  mem_ma [1024];
  logic [15:0] mem_mc [1024];

  always @(posedge clk) begin
    if (rom_cen) begin
      rom_ma <= mem_ma[rom_a];
      rom_mc <= mem_mc[rom_a];
    end
  end

  // scoreboard
  logic [9:0] exp_q [$];
  logic [9:0] exp_a;
  int checks   = 0;
  int failures = 0;

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input logic [9:0] a, input logic [2:0] op,
                     input logic [8:0] ma, input logic [8:0] tgt);
    mem_ma[a] = ma;
    mem_mc[a] = {op, 4'h0, tgt};
  endtask

  // Leaves the bench in the RST cycle with reset just released.
  task automatic do_reset();
    reset    = 1'b1;
    stall    = 1'b0;
    cond     = 1'b0;
    trap     = 1'b0;
    map_addr = 9'h000;
    exp_q.delete();
    for (int i = 0; i < 1024; i++) begin
      mem_ma[i] = 9'h000;
      mem_mc[i] = 16'h0000;
    end
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (dbg_state !== ST_RST) begin failures++; $display("FAIL rst_state got=%0d want=%0d", dbg_state, ST_RST); end
    checks++; if (rom_cen !== 1'b0) begin failures++; $display("FAIL rst_cen got=%b want=0", rom_cen); end
    checks++; if (rom_a !== 10'h000) begin failures++; $display("FAIL rst_rom_a got=%h want=000", rom_a); end
    checks++; if (uop_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", uop_valid); end
    checks++; if (upc !== 9'h000) begin failures++; $display("FAIL rst_upc got=%h want=000", upc); end
    checks++; if (trap_ack !== 1'b0) begin failures++; $display("FAIL rst_trap_ack got=%b want=0", trap_ack); end
    checks++; if (stk_err !== 1'b0) begin failures++; $display("FAIL rst_stk_err got=%b want=0", stk_err); end
    checks++; if (dbg_depth !== 3'd0) begin failures++; $display("FAIL rst_depth got=%0d want=0", dbg_depth); end

    put(10'h080, NEXT, 9'h085, 9'h000);
    put(10'h085, NEXT, 9'h085, 9'h000);
    exp_q.push_back(10'h080);
    exp_q.push_back(10'h085);
    exp_q.push_back(10'h085);
    for (int c = 0; c < 3; c++) begin
      cyc();
      #1;
      if (rom_cen) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL reset_fetch_extra rom_a=%h want=none", rom_a); end
        else begin exp_a = exp_q.pop_front(); if (rom_a !== exp_a) begin failures++; $display("FAIL reset_fetch got=%h want=%h", rom_a, exp_a); end end
      end
      if (c == 0) begin
        checks++; if (dbg_state !== ST_FETCH) begin failures++; $display("FAIL fetch_state got=%0d want=%0d", dbg_state, ST_FETCH); end
        checks++; if (uop_valid !== 1'b0) begin failures++; $display("FAIL fetch_valid got=%b want=0", uop_valid); end
      end
      if (c == 1) begin
        checks++; if (uop_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b want=1", uop_valid); end
        checks++; if (upc !== 9'h080) begin failures++; $display("FAIL first_upc got=%h want=080", upc); end
        checks++; if (uop !== {NEXT, 13'h0000}) begin failures++; $display("FAIL first_uop got=%h want=%h", uop, {NEXT, 13'h0000}); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL reset_missing left=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_br();
    do_reset();
    put(10'h080, BR, 9'h0A4, 9'h000);
    put(10'h0A5, BR, 9'h0A4, 9'h000);
    put(10'h0A4, NEXT, 9'h0A4, 9'h000);
    exp_q.push_back(10'h080);
    exp_q.push_back(10'h0A5);
    exp_q.push_back(10'h0A4);
    for (int c = 0; c < 3; c++) begin
      cyc();
      cond = (c == 2);
      #1;
      if (rom_cen) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL br_fetch_extra rom_a=%h want=none", rom_a); end
        else begin exp_a = exp_q.pop_front(); if (rom_a !== exp_a) begin failures++; $display("FAIL br_fetch got=%h want=%h", rom_a, exp_a); end end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL br_missing left=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_call_ret();
    // simple call / return
    do_reset();
    put(10'h080, CALL, 9'h090, 9'h120);
    put(10'h120, RET, 9'h000, 9'h000);
    put(10'h090, NEXT, 9'h090, 9'h000);
    exp_q.push_back(10'h080);
    exp_q.push_back(10'h120);
    exp_q.push_back(10'h090);
    exp_q.push_back(10'h090);
    for (int c = 0; c < 4; c++) begin
      cyc();
      #1;
      if (rom_cen) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL call_fetch_extra rom_a=%h want=none", rom_a); end
        else begin exp_a = exp_q.pop_front(); if (rom_a !== exp_a) begin failures++; $display("FAIL call_fetch got=%h want=%h", rom_a, exp_a); end end
      end
      if (c == 2) begin
        checks++; if (dbg_depth !== 3'd1) begin failures++; $display("FAIL call_depth got=%0d want=1", dbg_depth); end
      end
      if (c == 3) begin
        checks++; if (dbg_depth !== 3'd0) begin failures++; $display("FAIL ret_depth got=%0d want=0", dbg_depth); end
        checks++; if (stk_err !== 1'b0) begin failures++; $display("FAIL ret_stk_err got=%b want=0", stk_err); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL call_missing left=%0d want=0", exp_q.size()); end

    // five nested calls: oldest return address is dropped
    do_reset();
    put(10'h080, CALL, 9'h0C0, 9'h100);
    put(10'h100, CALL, 9'h0C1, 9'h101);
    put(10'h101, CALL, 9'h0C2, 9'h102);
    put(10'h102, CALL, 9'h0C3, 9'h103);
    put(10'h103, CALL, 9'h0C4, 9'h104);
    put(10'h104, RET, 9'h000, 9'h000);
    put(10'h0C4, RET, 9'h000, 9'h000);
    put(10'h0C3, RET, 9'h000, 9'h000);
    put(10'h0C2, RET, 9'h000, 9'h000);
    put(10'h0C1, RET, 9'h000, 9'h000);
    exp_q = '{10'h080, 10'h100, 10'h101, 10'h102, 10'h103, 10'h104,
              10'h0C4, 10'h0C3, 10'h0C2, 10'h0C1, 10'h000};
    for (int c = 0; c < 11; c++) begin
      cyc();
      #1;
      if (rom_cen) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL ovf_fetch_extra rom_a=%h want=none", rom_a); end
        else begin exp_a = exp_q.pop_front(); if (rom_a !== exp_a) begin failures++; $display("FAIL ovf_fetch got=%h want=%h", rom_a, exp_a); end end
      end
      if (c == 5) begin
        checks++; if (stk_err !== 1'b0) begin failures++; $display("FAIL ovf_err_early got=%b want=0", stk_err); end
      end
      if (c == 6) begin
        checks++; if (stk_err !== 1'b1) begin failures++; $display("FAIL ovf_err got=%b want=1", stk_err); end
        checks++; if (dbg_depth !== 3'd4) begin failures++; $display("FAIL ovf_depth got=%0d want=4", dbg_depth); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL ovf_missing left=%0d want=0", exp_q.size()); end

    // return with an empty stack
    do_reset();
    put(10'h080, RET, 9'h000, 9'h000);
    exp_q = '{10'h080, 10'h000, 10'h000};
    for (int c = 0; c < 3; c++) begin
      cyc();
      #1;
      if (rom_cen) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL unf_fetch_extra rom_a=%h want=none", rom_a); end
        else begin exp_a = exp_q.pop_front(); if (rom_a !== exp_a) begin failures++; $display("FAIL unf_fetch got=%h want=%h", rom_a, exp_a); end end
      end
      if (c == 1) begin
        checks++; if (stk_err !== 1'b0) begin failures++; $display("FAIL unf_err_early got=%b want=0", stk_err); end
      end
      if (c == 2) begin
        checks++; if (stk_err !== 1'b1) begin failures++; $display("FAIL unf_err got=%b want=1", stk_err); end
        checks++; if (dbg_depth !== 3'd0) begin failures++; $display("FAIL unf_depth got=%0d want=0", dbg_depth); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL unf_missing left=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_stall_wait();
    // stall on a CALL word for three cycles
    do_reset();
    put(10'h080, CALL, 9'h090, 9'h120);
    put(10'h120, RET, 9'h000, 9'h000);
    put(10'h090, NEXT, 9'h090, 9'h000);
    exp_q = '{10'h080, 10'h120, 10'h090, 10'h090};
    for (int c = 0; c < 7; c++) begin
      cyc();
      stall = (c >= 1 && c <= 3);
      #1;
      if (rom_cen) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL stall_fetch_extra rom_a=%h want=none", rom_a); end
        else begin exp_a = exp_q.pop_front(); if (rom_a !== exp_a) begin failures++; $display("FAIL stall_fetch got=%h want=%h", rom_a, exp_a); end end
      end
      if (c >= 1 && c <= 3) begin
        checks++; if (uop_valid !== 1'b0) begin failures++; $display("FAIL stall_valid c=%0d got=%b want=0", c, uop_valid); end
        checks++; if (rom_cen !== 1'b0) begin failures++; $display("FAIL stall_cen c=%0d got=%b want=0", c, rom_cen); end
        checks++; if (upc !== 9'h080) begin failures++; $display("FAIL stall_upc c=%0d got=%h want=080", c, upc); end
        checks++; if (dbg_depth !== 3'd0) begin failures++; $display("FAIL stall_depth c=%0d got=%0d want=0", c, dbg_depth); end
      end
      if (c == 5) begin
        checks++; if (dbg_depth !== 3'd1) begin failures++; $display("FAIL stall_push got=%0d want=1", dbg_depth); end
      end
      if (c == 6) begin
        checks++; if (dbg_depth !== 3'd0) begin failures++; $display("FAIL stall_pop got=%0d want=0", dbg_depth); end
      end
    end
    stall = 1'b0;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stall_missing left=%0d want=0", exp_q.size()); end

    // WAIT with cond low for four cycles
    do_reset();
    put(10'h080, WAITO, 9'h0D0, 9'h000);
    put(10'h0D0, NEXT, 9'h0D0, 9'h000);
    exp_q = '{10'h080, 10'h0D0, 10'h0D0};
    for (int c = 0; c < 7; c++) begin
      cyc();
      cond = (c >= 5);
      #1;
      if (rom_cen) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL wait_fetch_extra rom_a=%h want=none", rom_a); end
        else begin exp_a = exp_q.pop_front(); if (rom_a !== exp_a) begin failures++; $display("FAIL wait_fetch got=%h want=%h", rom_a, exp_a); end end
      end
      if (c >= 1 && c <= 4) begin
        checks++; if (uop_valid !== 1'b0) begin failures++; $display("FAIL wait_valid c=%0d got=%b want=0", c, uop_valid); end
        checks++; if (upc !== 9'h080) begin failures++; $display("FAIL wait_upc c=%0d got=%h want=080", c, upc); end
      end
      if (c == 5) begin
        checks++; if (uop_valid !== 1'b1) begin failures++; $display("FAIL wait_release got=%b want=1", uop_valid); end
      end
      if (c == 6) begin
        checks++; if (upc !== 9'h0D0) begin failures++; $display("FAIL wait_upc_after got=%h want=0D0", upc); end
      end
    end
    cond = 1'b0;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wait_missing left=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_trap_ax_map();
    do_reset();
    put(10'h080, SETAX, 9'h07F, 9'h000);
    put(10'h27F, CLRAX, 9'h060, 9'h000);
    put(10'h060, SETAX, 9'h070, 9'h000);
    put(10'h270, CALL, 9'h150, 9'h140);
    put(10'h081, MAP, 9'h000, 9'h000);
    put(10'h033, NEXT, 9'h033, 9'h000);
    map_addr = 9'h033;
    exp_q = '{10'h080, 10'h27F, 10'h060, 10'h270, 10'h081, 10'h033, 10'h033};
    for (int c = 0; c < 8; c++) begin
      cyc();
      stall = (c == 4);
      trap  = (c == 4 || c == 5);
      #1;
      if (rom_cen) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL tam_fetch_extra rom_a=%h want=none", rom_a); end
        else begin exp_a = exp_q.pop_front(); if (rom_a !== exp_a) begin failures++; $display("FAIL tam_fetch got=%h want=%h", rom_a, exp_a); end end
      end
      if (c == 4) begin
        checks++; if (trap_ack !== 1'b0) begin failures++; $display("FAIL trap_stall_ack got=%b want=0", trap_ack); end
        checks++; if (uop_valid !== 1'b0) begin failures++; $display("FAIL trap_stall_valid got=%b want=0", uop_valid); end
      end
      if (c == 5) begin
        checks++; if (trap_ack !== 1'b1) begin failures++; $display("FAIL trap_ack got=%b want=1", trap_ack); end
        checks++; if (uop_valid !== 1'b1) begin failures++; $display("FAIL trap_valid got=%b want=1", uop_valid); end
      end
      if (c == 6) begin
        checks++; if (trap_ack !== 1'b0) begin failures++; $display("FAIL trap_pulse got=%b want=0", trap_ack); end
        checks++; if (dbg_depth !== 3'd0) begin failures++; $display("FAIL trap_depth got=%0d want=0", dbg_depth); end
      end
    end
    stall = 1'b0;
    trap  = 1'b0;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL tam_missing left=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int c;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      put(10'h080 + 10'(i), NEXT, 9'h081 + 9'(i), 9'h000);
      exp_q.push_back(10'h080 + 10'(i));
    end
    put(10'h0A8, NEXT, 9'h0A8, 9'h000);
    exp_q.push_back(10'h0A8);
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      cyc();
      stall = (c >= 1) && ($urandom_range(0, 3) == 0);
      #1;
      if (rom_cen) begin
        exp_a = exp_q.pop_front();
        checks++; if (rom_a !== exp_a) begin failures++; $display("FAIL b2b_fetch got=%h want=%h", rom_a, exp_a); end
      end
      if (c >= 1) begin
        checks++; if (uop_valid !== !stall) begin failures++; $display("FAIL b2b_valid c=%0d got=%b want=%b", c, uop_valid, !stall); end
      end
      c++;
    end
    stall = 1'b0;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_timeout left=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_br();
    test_call_ret();
    test_stall_wait();
    test_trap_ax_map();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dc_useq.md
# dc_useq

Microsequencer for the F11 microcode store: drives the 10-bit address, `cen` and the AX line of the registered MicROM, and consumes the returned 9-bit next-address field `ma` and 16-bit microword `mc`. It selects every next address from the ROM link field, a conditional branch, a 4-deep subroutine stack, the PLA map address, or the trap vector. It issues one microinstruction per clock to the datapath and handles stalls, wait states and trap entry.

## Interface
- `RESET_VEC`, 9'h080: microaddress fetched first after reset.
- `TRAP_VEC`, 9'h081: microaddress entered when a trap is taken.
- `clk` in 1: single clock; every register updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `stall` in 1: datapath not ready; freezes sequencing.
- `cond` in 1: branch/wait condition from the datapath, valid in the cycle the microword is visible.
- `map_addr` in 9: PLA map target address.
- `trap` in 1: level trap request; held by its source until `trap_ack`.
- `rom_ma` in 9: MicROM next-address field of the current word.
- `rom_mc` in 16: MicROM microword of the current word.
- `rom_a` out 10: MicROM address, {ax, addr[8:0]}.
- `rom_cen` out 1: MicROM fetch enable.
- `uop` out 16: current microword (equals `rom_mc`).
- `uop_valid` out 1: the datapath executes `uop` this cycle.
- `upc` out 9: address of the word in `uop`.
- `trap_ack` out 1: one-cycle pulse when a trap is taken.
- `stk_err` out 1: sticky flag for stack overflow or underflow.

## Operation
- States: RST, FETCH, RUN.
  - RST is held while `reset`=1.
  - RST goes to FETCH unconditionally.
  - FETCH issues `RESET_VEC` with `rom_cen`=1 and goes to RUN.
  - RUN stays in RUN.
- ROM latency is 1: an address issued with `rom_cen`=1 in cycle n produces `rom_ma`/`rom_mc` in cycle n+1. Those outputs stay stable while `rom_cen`=0.
- In RUN, `rom_mc[15:13]` is the sequencing opcode:
  - 000 NEXT: next = `rom_ma`.
  - 001 BR: next = `cond` ? `rom_ma` : (`rom_ma` | 9'h001).
  - 010 CALL: push `rom_ma`; next = `rom_mc[8:0]`.
  - 011 RET: next = pop.
  - 100 MAP: next = `map_addr`.
  - 101 SETAX: next = `rom_ma`; ax <= 1.
  - 110 CLRAX: next = `rom_ma`; ax <= 0.
  - 111 WAIT: next = `rom_ma`, and advance only when `cond`=1.
- advance = RUN & ~`stall` & ~(WAIT & ~`cond`).
- `rom_cen` = advance | FETCH.
- `uop_valid` = advance.
- Stack, push, pop and ax change only on advance, so a stalled word never double-pushes.
- `rom_a` is combinational from the current word and state. `upc` registers the issued address on each fetch.
- Trap:
  - If `trap`=1 on an advancing cycle, next = `TRAP_VEC` and ax <= 0.
  - The current word still executes (`uop_valid`=1), but its push, pop and ax effect are suppressed.
  - `trap_ack`=1 in that cycle.
  - Trap has priority over every opcode.
- Stack: 4 entries, depth counter 0..4.
  - Push at depth 4 overwrites the oldest entry, keeps depth at 4 and sets `stk_err`.
  - Pop at depth 0 returns 9'h000 and sets `stk_err`.
  - `stk_err` clears only on `reset`.

## Timing
- Reset values: state RST, `rom_cen`=0, `rom_a`=10'h000, `uop_valid`=0, `upc`=9'h000, `trap_ack`=0, `stk_err`=0, ax=0, stack depth 0.
- Reset startup sequence:
  - Cycle 0: `reset` deasserts.
  - Cycle 1 (RST): outputs idle.
  - Cycle 2 (FETCH): `rom_a`={0,`RESET_VEC`}, `rom_cen`=1.
  - Cycle 3: first word appears with `uop_valid`=1 unless stalled.
- Steady state throughput is one word per clock. The next address is issued in the same cycle the current word is executed.
- `stall` or WAIT hold: `rom_cen`=0, `uop_valid`=0, and `uop`/`upc` remain unchanged.
- `reset` asserted mid-RUN: the next edge forces the reset values. Any in-flight ROM word is ignored.
- Simultaneous `trap` and `stall`: no action until `stall` drops, then the trap is taken.
- The AX change from SETAX/CLRAX appears in `rom_a[9]` of the very next fetch.

## Test plan
- Reset: release `reset`, ROM word at 9'h080 = {NEXT, ma=9'h085} → `rom_a`=10'h080 in cycle 2, `uop_valid` in cycle 3, `rom_a`=10'h085 in the same cycle.
- BR: word {BR, ma=9'h0A4} with `cond`=0 → next `rom_a`=10'h0A5; with `cond`=1 → 10'h0A4.
- CALL/RET: CALL target 9'h120, ma=9'h090, then RET at 9'h120 → fetch 9'h120, then 9'h090, depth back to 0, `stk_err`=0. Five nested CALLs → `stk_err`=1; first RET at empty depth after reset → next 9'h000, `stk_err`=1.
- Stall/WAIT: `stall`=1 for 3 cycles on a CALL word → `uop_valid`=0 and `rom_cen`=0 for 3 cycles, exactly one push. WAIT with `cond` low 4 cycles → address held, then advance to `rom_ma` on `cond`=1.
- Trap/AX/MAP: SETAX with ma=9'h07F → `rom_a`=10'h27F. Trap on a CALL word → `trap_ack` pulse, `rom_a`=10'h081, depth unchanged. MAP with `map_addr`=9'h033 → `rom_a`=10'h033.
